lsu_align_unit: RTL and testbench
=================================

# lsu_align_unit

Parametrised load/store alignment unit between the CPU datapath's memory stage and the D-cache port. Accepts one byte/half/word/dword access per request, generates aligned addresses and byte enables, shifts store data, and extracts plus sign/zero-extends load data. Unlike the fixed 32-bit single-access path, it is width-generic and splits misaligned accesses that straddle a data-word boundary into two sequential cache transactions, merging the results.

## Interface
Parameters:
- DATA_W, 32, data-port width in bits; legal values 32 or 64. B = DATA_W/8 bytes, OFS_W = log2(B).
- ADDR_W, 32, byte-address width.
- SPLIT_EN, 1, 1 = split straddling accesses into two transactions; 0 = straddling access faults with no memory traffic.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse (loads and stores).
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and faults.
- rsp_fault  out  1  qualifies rsp_valid: illegal size or straddle with SPLIT_EN=0.
- d_mem_read  out  1  cache read strobe.
- d_mem_write  out  1  cache write strobe.
- d_mem_address  out  ADDR_W  aligned address, low OFS_W bits always 0.
- d_mem_byte_en  out  B  byte enables.
- d_mem_wdata  out  DATA_W  lane-positioned store data.
- d_mem_resp  in  1  cache completes current transaction.
- d_mem_rdata  in  DATA_W  cache read data, valid with d_mem_resp.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP. Handshake: request captured on edge where req_valid && req_ready; all req_* fields registered then.
- On capture: off = addr[OFS_W-1:0]; N = 1<<size; mask2 = ((1<<N)-1) << off, 2B bits; lo_en = mask2[B-1:0], hi_en = mask2[2B-1:B]; wdata2 = wdata << (8*off), 2*DATA_W bits.
- Illegal size (size=3 with DATA_W=32) or (hi_en!=0 and SPLIT_EN=0): IDLE -> RESP with fault=1, no memory strobe.
- Otherwise IDLE -> ACC0. ACC0 drives address {addr[ADDR_W-1:OFS_W], 0}, byte_en = lo_en, wdata = wdata2 low half, read/write per req_we.
- ACC0 on d_mem_resp: latch rdata into lo buffer; if hi_en==0 -> RESP, else -> ACC1.
- ACC1 drives aligned address + B (wraps modulo 2^ADDR_W), byte_en = hi_en, wdata = wdata2 high half; on d_mem_resp latch hi buffer -> RESP.
- Load result: ({hi, lo} >> 8*off) truncated to N bytes, then zero- or sign-extended (sign bit = bit 8N-1) to DATA_W. Result registered into rsp_rdata on entry to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
- d_mem_resp outside ACC0/ACC1 is ignored.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0, d_mem_read=0, d_mem_write=0, d_mem_address=0, d_mem_byte_en=0, d_mem_wdata=0. Requests are ignored while rst=0.
- Strobes and address/byte_en/wdata are registered, held stable from the first ACCx cycle until the cycle d_mem_resp is sampled high, and deasserted (or changed to the ACC1 values) the following cycle.
- Latency with 0-wait cache (resp in first strobe cycle): accept at cycle 0, strobe cycle 1, rsp_valid cycle 2; split: strobes cycles 1 and 2, rsp_valid cycle 3. Fault: rsp_valid cycle 1.
- Each wait cycle of d_mem_resp adds one cycle. req_ready low from capture through the RESP cycle; next accept possible the cycle after RESP.
- Reset assertion mid-transaction: all outputs to reset values immediately (asynchronous); in-flight cache transaction abandoned, no rsp_valid produced.

## Test plan
- DATA_W=32, aligned lw addr 0x100, cache returns 0xDEADBEEF in 0 waits -> one read, addr 0x100, byte_en 1111; rsp_valid cycle 2, rdata 0xDEADBEEF, fault 0.
- lb addr 0x103, rdata 0x80112233, unsigned=0 -> byte_en 1000, rsp_rdata 0xFFFFFF80; same with unsigned=1 -> 0x00000080.
- sh addr 0x102, wdata 0x0000ABCD -> single write, byte_en 1100, wdata 0xABCD0000, rsp_valid with rdata 0.
- SPLIT_EN=1, lw addr 0x0FE, words at 0x0FC=0x44332211 and 0x100=0x88776655 -> two reads (byte_en 1100 then 0011), rsp_rdata 0x66554433, rsp_valid cycle 3; add 2 wait states on second -> cycle 5.
- SPLIT_EN=0, same lw 0x0FE -> no strobes, rsp_fault=1 at cycle 1; DATA_W=32 with size=3 -> fault likewise; DATA_W=64 ld addr 0x7 splits (byte_en 0x80 then 0x7F).
- Deassert rst during ACC1 with a pending read -> strobes drop same cycle, no rsp_valid; after release, a new aligned lw completes normally.

Source files
------------

// File: rtl/lsu_align_unit_if.sv
// Request/response and D-cache port bundle for lsu_align_unit.
// "slave" is the alignment unit's view; "master" is the CPU/cache side.
interface lsu_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int B = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_address;
  logic [B-1:0]      d_mem_byte_en;
  logic [DATA_W-1:0] d_mem_wdata;
  logic              d_mem_resp;
  logic [DATA_W-1:0] d_mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  d_mem_resp, d_mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_byte_en, d_mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output d_mem_resp, d_mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_byte_en, d_mem_wdata
  );
endinterface

// File: rtl/lsu_align_unit.sv
// Width-generic load/store alignment unit: byte enables, store lane shifting,
// load extraction/extension, and two-transaction split of straddling accesses.
module lsu_align_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  lsu_align_unit_if.slave bus
);
  localparam int B     = DATA_W / 8;
  localparam int OFS_W = $clog2(B);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [OFS_W-1:0]  off_q, off_d;
  logic [B-1:0]      hi_en_q, hi_en_d;
  logic [DATA_W-1:0] wdata_hi_q, wdata_hi_d;
  logic [DATA_W-1:0] lo_buf_q, lo_buf_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [B-1:0]      be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic [OFS_W-1:0]    off_c;
  logic [2*B-1:0]      nmask_c, mask2_c;
  logic [2*DATA_W-1:0] wdata2_c;
  logic                illegal_c, fault_c;

  // Request decode: byte mask and store data positioned across two data words.
  always_comb begin
    off_c = bus.req_addr[OFS_W-1:0];
    case (bus.req_size)
      2'd0:    nmask_c = (2*B)'(1);
      2'd1:    nmask_c = (2*B)'(3);
      2'd2:    nmask_c = (2*B)'(15);
      default: nmask_c = (2*B)'(255);
    endcase
    mask2_c   = nmask_c << off_c;
    wdata2_c  = {{DATA_W{1'b0}}, bus.req_wdata} << {off_c, 3'b000};
    illegal_c = (bus.req_size == 2'd3) && (DATA_W == 32);
    fault_c   = illegal_c || ((|mask2_c[2*B-1:B]) && !SPLIT_EN);
  end

  logic [2*DATA_W-1:0] pair_c;
  logic [DATA_W-1:0]   raw_c, keep_c, load_c;
  logic [7:0]          nbits_c;
  logic                sign_c;

  // Load extraction uses the live cache data for the final transaction.
  always_comb begin
    pair_c  = (state_q == ACC1) ? {bus.d_mem_rdata, lo_buf_q}
                                : {{DATA_W{1'b0}}, bus.d_mem_rdata};
    raw_c   = DATA_W'(pair_c >> {off_q, 3'b000});
    nbits_c = 8'd8 << size_q;
    keep_c  = ~({DATA_W{1'b1}} << nbits_c);
    sign_c  = !uns_q && (|(raw_c & (keep_c ^ (keep_c >> 1))));
    load_c  = sign_c ? (raw_c | ~keep_c) : (raw_c & keep_c);
  end

  logic done_c;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    uns_d      = uns_q;
    size_d     = size_q;
    off_d      = off_q;
    hi_en_d    = hi_en_q;
    wdata_hi_d = wdata_hi_q;
    lo_buf_d   = lo_buf_q;
    read_d     = read_q;
    write_d    = write_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    done_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          uns_d      = bus.req_unsigned;
          size_d     = bus.req_size;
          off_d      = off_c;
          hi_en_d    = mask2_c[2*B-1:B];
          wdata_hi_d = wdata2_c[2*DATA_W-1:DATA_W];
          if (fault_c) begin
            state_d = RESP;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACC0;
            fault_d = 1'b0;
            read_d  = !bus.req_we;
            write_d = bus.req_we;
            addr_d  = {bus.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            be_d    = mask2_c[B-1:0];
            wdata_d = wdata2_c[DATA_W-1:0];
          end
        end
      end
      ACC0: begin
        if (bus.d_mem_resp) begin
          lo_buf_d = bus.d_mem_rdata;
          if (hi_en_q == '0) begin
            done_c = 1'b1;
          end else begin
            state_d = ACC1;
            addr_d  = addr_q + ADDR_W'(B);
            be_d    = hi_en_q;
            wdata_d = wdata_hi_q;
          end
        end
      end
      ACC1: begin
        if (bus.d_mem_resp) done_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (done_c) begin
      state_d = RESP;
      read_d  = 1'b0;
      write_d = 1'b0;
      addr_d  = '0;
      be_d    = '0;
      wdata_d = '0;
      rdata_d = we_q ? '0 : load_c;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'd0;
      off_q      <= '0;
      hi_en_q    <= '0;
      wdata_hi_q <= '0;
      lo_buf_q   <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      size_q     <= size_d;
      off_q      <= off_d;
      hi_en_q    <= hi_en_d;
      wdata_hi_q <= wdata_hi_d;
      lo_buf_q   <= lo_buf_d;
      read_q     <= read_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_fault     = fault_q;
  assign bus.d_mem_read    = read_q;
  assign bus.d_mem_write   = write_q;
  assign bus.d_mem_address = addr_q;
  assign bus.d_mem_byte_en = be_q;
  assign bus.d_mem_wdata   = wdata_q;
endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench: 32-bit split, 32-bit non-split and 64-bit split instances
// share one request bus; each has its own cache model.
module tb_lsu_align_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        t_we = 1'b0, t_uns = 1'b0;
  logic [1:0]  t_size = 2'd0;
  logic [31:0] t_addr = '0;
  logic [63:0] t_wdata = '0;
  logic        v32 = 1'b0, vn = 1'b0, v64 = 1'b0;

  lsu_align_unit_if #(.DATA_W(32), .ADDR_W(32)) m32 ();
  lsu_align_unit_if #(.DATA_W(32), .ADDR_W(32)) mn ();
  lsu_align_unit_if #(.DATA_W(64), .ADDR_W(32)) m64 ();

  lsu_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b1)) u_a32 (.clk(clk), .rst(rst), .bus(m32.slave));
  lsu_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b0)) u_n32 (.clk(clk), .rst(rst), .bus(mn.slave));
  lsu_align_unit #(.DATA_W(64), .ADDR_W(32), .SPLIT_EN(1'b1)) u_a64 (.clk(clk), .rst(rst), .bus(m64.slave));

  assign m32.req_valid = v32;   assign mn.req_valid = vn;   assign m64.req_valid = v64;
  assign m32.req_we = t_we;     assign mn.req_we = t_we;    assign m64.req_we = t_we;
  assign m32.req_size = t_size; assign mn.req_size = t_size; assign m64.req_size = t_size;
  assign m32.req_unsigned = t_uns; assign mn.req_unsigned = t_uns; assign m64.req_unsigned = t_uns;
  assign m32.req_addr = t_addr; assign mn.req_addr = t_addr; assign m64.req_addr = t_addr;
  assign m32.req_wdata = t_wdata[31:0];
  assign mn.req_wdata  = t_wdata[31:0];
  assign m64.req_wdata = t_wdata;

  // Non-split instance: cache never answers, any strobe is an error.
  assign mn.d_mem_resp  = 1'b0;
  assign mn.d_mem_rdata = '0;
  // 64-bit instance: zero-wait cache with two fixed dwords.
  assign m64.d_mem_resp  = 1'b1;
  assign m64.d_mem_rdata = (m64.d_mem_address == 32'h0) ? 64'h8877_6655_4433_2211 :
                           (m64.d_mem_address == 32'h8) ? 64'h00FF_EEDD_CCBB_AA99 : 64'h0;

  // 32-bit cache model with per-transaction wait states and a transaction log.
  logic [31:0] mem32 [0:255];
  int          waits0 = 0, waits1 = 0;
  int          wcnt = 0, acc_idx = 0, log_n = 0;
  logic        mresp = 1'b0;
  logic [31:0] mrdata = '0;
  logic [31:0] log_addr  [0:63];
  logic [3:0]  log_be    [0:63];
  logic [31:0] log_wdata [0:63];
  logic        log_we    [0:63];
  assign m32.d_mem_resp  = mresp;
  assign m32.d_mem_rdata = mrdata;

  always @(negedge clk) begin
    if (mresp) begin
      mresp = 1'b0;
      wcnt  = 0;
      acc_idx++;
    end
    if (m32.req_ready) acc_idx = 0;
    if (rst && (m32.d_mem_read || m32.d_mem_write)) begin
      if (wcnt >= ((acc_idx == 0) ? waits0 : waits1)) begin
        mresp  = 1'b1;
        mrdata = mem32[m32.d_mem_address[9:2]];
        if (log_n < 64) begin
          log_addr[log_n]  = m32.d_mem_address;
          log_be[log_n]    = m32.d_mem_byte_en;
          log_wdata[log_n] = m32.d_mem_wdata;
          log_we[log_n]    = m32.d_mem_write;
        end
        log_n++;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  int rsp_cnt32 = 0, nstrobe = 0, l64_n = 0;
  logic [7:0]  l64_be   [0:15];
  logic [31:0] l64_addr [0:15];
  always @(negedge clk) begin
    if (m32.rsp_valid) rsp_cnt32++;
    if (mn.d_mem_read || mn.d_mem_write) nstrobe++;
    if (m64.d_mem_read) begin
      if (l64_n < 16) begin
        l64_be[l64_n]   = m64.d_mem_byte_en;
        l64_addr[l64_n] = m64.d_mem_address;
      end
      l64_n++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rv(input int inst);
    case (inst)
      0:       return m32.rsp_valid;
      1:       return mn.rsp_valid;
      default: return m64.rsp_valid;
    endcase
  endfunction

  function automatic logic rdy(input int inst);
    case (inst)
      0:       return m32.req_ready;
      1:       return mn.req_ready;
      default: return m64.req_ready;
    endcase
  endfunction

  function automatic logic [63:0] rd(input int inst);
    case (inst)
      0:       return {32'h0, m32.rsp_rdata};
      1:       return {32'h0, mn.rsp_rdata};
      default: return m64.rsp_rdata;
    endcase
  endfunction

  function automatic logic ft(input int inst);
    case (inst)
      0:       return m32.rsp_fault;
      1:       return mn.rsp_fault;
      default: return m64.rsp_fault;
    endcase
  endfunction

  // One request; lat is the cycle (accept = 0) in which rsp_valid is seen.
  task automatic do_req(input int inst, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        output int lat, output logic [63:0] rdata, output logic fault);
    @(negedge clk);
    t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata;
    check("req_ready_idle", rdy(inst), 1'b1);
    v32 = (inst == 0); vn = (inst == 1); v64 = (inst == 2);
    @(negedge clk);
    v32 = 1'b0; vn = 1'b0; v64 = 1'b0;
    lat = 1;
    while (!rv(inst) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = rd(inst);
    fault = ft(inst);
    $display("req inst=%0d we=%0d size=%0d uns=%0d addr=%h -> lat=%0d rdata=%h fault=%0d",
             inst, we, size, uns, addr, lat, rdata, fault);
    @(negedge clk);
    check("rsp_valid_one_cycle", rv(inst), 1'b0);
  endtask

  int          lat, base;
  logic [63:0] rdata;
  logic        fault;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready",  m32.req_ready, 1'b1);
    check("rst_valid",  m32.rsp_valid, 1'b0);
    check("rst_fault",  m32.rsp_fault, 1'b0);
    check("rst_rdata",  m32.rsp_rdata, 32'h0);
    check("rst_read",   m32.d_mem_read, 1'b0);
    check("rst_write",  m32.d_mem_write, 1'b0);
    check("rst_addr",   m32.d_mem_address, 32'h0);
    check("rst_be",     m32.d_mem_byte_en, 4'h0);
    check("rst_wdata",  m32.d_mem_wdata, 32'h0);
    rst = 1'b1;

    // Aligned lw.
    mem32[8'h40] = 32'hDEAD_BEEF;
    base = log_n;
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 64'h0, lat, rdata, fault);
    check("lw_lat", lat, 2);
    check("lw_rdata", rdata, 64'hDEAD_BEEF);
    check("lw_fault", fault, 1'b0);
    check("lw_ntrans", log_n - base, 1);
    check("lw_addr", log_addr[base], 32'h100);
    check("lw_be", log_be[base], 4'hF);
    check("lw_we", log_we[base], 1'b0);

    // lb at offset 3, signed and unsigned.
    mem32[8'h40] = 32'h8011_2233;
    base = log_n;
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h103, 64'h0, lat, rdata, fault);
    check("lb_s_rdata", rdata, 64'hFFFF_FF80);
    check("lb_s_be", log_be[base], 4'h8);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h103, 64'h0, lat, rdata, fault);
    check("lb_u_rdata", rdata, 64'h0000_0080);

    // sh at offset 2.
    base = log_n;
    do_req(0, 1'b1, 2'd1, 1'b0, 32'h102, 64'h0000_ABCD, lat, rdata, fault);
    check("sh_lat", lat, 2);
    check("sh_rdata", rdata, 64'h0);
    check("sh_ntrans", log_n - base, 1);
    check("sh_be", log_be[base], 4'hC);
    check("sh_wdata", log_wdata[base], 32'hABCD_0000);
    check("sh_we", log_we[base], 1'b1);

    // Straddling lw: split into two reads.
    mem32[8'h3F] = 32'h4433_2211;
    mem32[8'h40] = 32'h8877_6655;
    base = log_n;
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h0FE, 64'h0, lat, rdata, fault);
    check("split_lat", lat, 3);
    check("split_rdata", rdata, 64'h6655_4433);
    check("split_ntrans", log_n - base, 2);
    check("split_addr0", log_addr[base], 32'h0FC);
    check("split_be0", log_be[base], 4'hC);
    check("split_addr1", log_addr[base+1], 32'h100);
    check("split_be1", log_be[base+1], 4'h3);
    waits1 = 2;
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h0FE, 64'h0, lat, rdata, fault);
    check("split_wait_lat", lat, 5);
    check("split_wait_rdata", rdata, 64'h6655_4433);
    waits1 = 0;

    // Dword size on a 32-bit port faults without traffic.
    base = log_n;
    do_req(0, 1'b0, 2'd3, 1'b0, 32'h100, 64'h0, lat, rdata, fault);
    check("ill_lat", lat, 1);
    check("ill_fault", fault, 1'b1);
    check("ill_rdata", rdata, 64'h0);
    check("ill_ntrans", log_n - base, 0);

    // Non-split instance: straddle and illegal size both fault.
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h0FE, 64'h0, lat, rdata, fault);
    check("nosplit_lat", lat, 1);
    check("nosplit_fault", fault, 1'b1);
    check("nosplit_rdata", rdata, 64'h0);
    do_req(1, 1'b0, 2'd3, 1'b0, 32'h100, 64'h0, lat, rdata, fault);
    check("nosplit_ill_fault", fault, 1'b1);
    check("nosplit_strobes", nstrobe, 0);

    // 64-bit ld at offset 7 splits.
    do_req(2, 1'b0, 2'd3, 1'b0, 32'h7, 64'h0, lat, rdata, fault);
    check("ld64_lat", lat, 3);
    check("ld64_rdata", rdata, 64'hFFEE_DDCC_BBAA_9988);
    check("ld64_fault", fault, 1'b0);
    check("ld64_ntrans", l64_n, 2);
    check("ld64_be0", l64_be[0], 8'h80);
    check("ld64_addr0", l64_addr[0], 32'h0);
    check("ld64_be1", l64_be[1], 8'h7F);
    check("ld64_addr1", l64_addr[1], 32'h8);

    // Reset during ACC1 with a pending read.
    waits1 = 5;
    @(negedge clk);
    t_we = 1'b0; t_size = 2'd2; t_uns = 1'b0; t_addr = 32'h0FE; t_wdata = '0;
    v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    @(negedge clk);
    check("rst_mid_pre_read", m32.d_mem_read, 1'b1);
    check("rst_mid_pre_addr", m32.d_mem_address, 32'h100);
    base = rsp_cnt32;
    #2 rst = 1'b0;
    #1;
    check("rst_mid_read", m32.d_mem_read, 1'b0);
    check("rst_mid_addr", m32.d_mem_address, 32'h0);
    check("rst_mid_be", m32.d_mem_byte_en, 4'h0);
    check("rst_mid_ready", m32.req_ready, 1'b1);
    $display("reset asserted mid-ACC1: read=%0d ready=%0d", m32.d_mem_read, m32.req_ready);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_no_rsp", rsp_cnt32, base);
    check("rst_mid_idle_read", m32.d_mem_read, 1'b0);
    waits1 = 0;

    mem32[8'h40] = 32'hDEAD_BEEF;
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 64'h0, lat, rdata, fault);
    check("post_rst_lat", lat, 2);
    check("post_rst_rdata", rdata, 64'hDEAD_BEEF);
    check("post_rst_fault", fault, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
